// File: rtl/pipeline_controller_pkg.sv
// Shared state encodings, control-bundle type and hazard helper for the
// mips32 pipeline controller.
package pipeline_controller_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } pipe_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // One strobe per pipeline-register control plus the mult/div status bits.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic ex_mem_flush;
        logic mem_wb_flush;
        logic md_busy;
        logic md_done;
    } pipe_ctrl_t;

    // Everything advances, nothing is squashed.
    localparam pipe_ctrl_t CTRL_RUN = '{
        pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
        id_ex_write: 1'b1, id_ex_flush: 1'b0, ex_mem_write: 1'b1,
        ex_mem_flush: 1'b0, mem_wb_flush: 1'b0, md_busy: 1'b0, md_done: 1'b0};

    // Nothing is written, every register loads a bubble: one cycle clears the pipe.
    localparam pipe_ctrl_t CTRL_RESET = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
        id_ex_write: 1'b0, id_ex_flush: 1'b1, ex_mem_write: 1'b0,
        ex_mem_flush: 1'b1, mem_wb_flush: 1'b1, md_busy: 1'b0, md_done: 1'b0};

    // MEM waits on data memory: freeze everything up to EX/MEM, bubble into WB.
    localparam pipe_ctrl_t CTRL_MEM_STALL = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
        id_ex_write: 1'b0, id_ex_flush: 1'b0, ex_mem_write: 1'b0,
        ex_mem_flush: 1'b0, mem_wb_flush: 1'b1, md_busy: 1'b0, md_done: 1'b0};

    // Mult/div holds EX: freeze front end, feed bubbles downstream of EX.
    localparam pipe_ctrl_t CTRL_MD_STALL = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
        id_ex_write: 1'b0, id_ex_flush: 1'b0, ex_mem_write: 1'b1,
        ex_mem_flush: 1'b1, mem_wb_flush: 1'b0, md_busy: 1'b1, md_done: 1'b0};

    // A load in EX feeds a source of the instruction in ID; $0 never counts.
    function automatic logic load_use_hazard(input logic       mem_read_ex,
                                             input logic [4:0] rs_id,
                                             input logic [4:0] rt_id,
                                             input logic [4:0] rt_ex);
        return mem_read_ex && (rt_ex != REG_ZERO) &&
               ((rs_id == rt_ex) || (rt_id == rt_ex));
    endfunction

endpackage

// File: rtl/pipeline_controller_md_latency_counter.sv
// Loadable down-counter that times how long a mult/div occupies EX.
module md_latency_counter
    import pipeline_controller_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             enable,
    output logic             zero,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: a load wins over a decrement.
    always_comb begin
        // NOTE: assign a default first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (enable) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero  = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/pipeline_controller.sv
// Central stall/flush sequencer for the 5-stage mips32 pipeline.
// Optional build macro PIPELINE_CTRL_PERF_EN adds the stall and branch-flush
// performance counters; without it both counter ports are tied to zero.
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic [4:0]  rt_ex,
    input  logic        mem_read_ex,
    input  logic        branch_taken,
    input  logic        md_start,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_write,
    output logic        id_ex_flush,
    output logic        ex_mem_write,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    pipe_state_e      state_q;
    pipe_state_e      state_d;
    pipe_ctrl_t       ctrl;
    logic             md_load;
    logic             md_dec;
    logic             md_zero;
    logic [CNT_W-1:0] md_count;

    // The start cycle is the first of MD_LATENCY, and MD_WAIT ends on count 0.
    localparam logic [CNT_W-1:0] MD_LOAD_VAL = CNT_W'(MD_LATENCY - 2);

    // Pipeline FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and strobes; priority in RUN is MEM stall > branch > mult/div > load-use.
    always_comb begin
        state_d = state_q;
        ctrl    = CTRL_RUN;
        md_load = 1'b0;
        if (reset) begin
            ctrl    = CTRL_RESET;
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        ctrl    = CTRL_MEM_STALL;
                        state_d = MEM_WAIT;
                    end else if (branch_taken) begin
                        // The would-be load-use consumer is squashed, so no stall.
                        ctrl.if_id_flush = 1'b1;
                        ctrl.id_ex_flush = 1'b1;
                    end else if (md_start) begin
                        ctrl    = CTRL_MD_STALL;
                        md_load = 1'b1;
                        state_d = MD_WAIT;
                    end else if (load_use_hazard(mem_read_ex, rs_id, rt_id, rt_ex)) begin
                        ctrl.pc_write    = 1'b0;
                        ctrl.if_id_write = 1'b0;
                        ctrl.id_ex_flush = 1'b1;
                    end
                end
                MD_WAIT: begin
                    // Only bubbles sit downstream of EX, so branches and MEM requests are moot.
                    ctrl = CTRL_MD_STALL;
                    if (md_zero) begin
                        ctrl.md_done = 1'b1;
                        state_d      = RUN;
                    end
                end
                MEM_WAIT: begin
                    if (!dmem_ready) begin
                        ctrl = CTRL_MEM_STALL;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    assign md_dec = (state_q == MD_WAIT) && (md_count != '0);

    md_latency_counter #(
        .CNT_W (CNT_W)
    ) u_md_latency_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (md_load),
        .load_val (MD_LOAD_VAL),
        .enable   (md_dec),
        .zero     (md_zero),
        .count    (md_count)
    );

    assign pc_write     = ctrl.pc_write;
    assign if_id_write  = ctrl.if_id_write;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_write  = ctrl.id_ex_write;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_write = ctrl.ex_mem_write;
    assign ex_mem_flush = ctrl.ex_mem_flush;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign md_busy      = ctrl.md_busy;
    assign md_done      = ctrl.md_done;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;
    logic [31:0] flush_count_q;
    logic [31:0] flush_count_d;
    logic        branch_flush;

    // Outside reset, IF/ID is only flushed by a taken branch.
    assign branch_flush = ctrl.if_id_flush && !reset;

    // Counter increments; both wrap naturally at 2^32.
    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, ~ctrl.pc_write};
        flush_count_d  = flush_count_q + {31'd0, branch_flush};
    end

    // Performance counter registers, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: a RUN-state vector table,
// hand-written multi-cycle sequences, then randomized traffic compared each
// cycle against a behavioural model of the stall/flush rules.
module tb_pipeline_controller;

    localparam int MD_LAT = 4;

    // Expected strobes, MSB first:
    // pc_w, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, ex_mem_f, mem_wb_f, md_busy, md_done
    localparam logic [9:0] E_RUN  = 10'b1101010000;
    localparam logic [9:0] E_LU   = 10'b0001110000;
    localparam logic [9:0] E_BR   = 10'b1111110000;
    localparam logic [9:0] E_MD   = 10'b0000011010;
    localparam logic [9:0] E_DONE = 10'b0000011011;
    localparam logic [9:0] E_MEM  = 10'b0000000100;
    localparam logic [9:0] E_RST  = 10'b0010101100;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rs_id, rt_id, rt_ex;
    logic        mem_read_ex, branch_taken, md_start, dmem_req, dmem_ready;
    logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic        ex_mem_write, ex_mem_flush, mem_wb_flush, md_busy, md_done;
    logic [31:0] stall_cycles, flush_count;
    logic [9:0]  outs;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: cycles of EX occupancy still to come, and data-memory wait.
    int          md_left = 0;
    bit          mem_wait = 1'b0;
    logic [31:0] m_stall = 32'd0;
    logic [31:0] m_flush = 32'd0;

    typedef struct {
        logic [4:0] rs, rt, rtx;
        logic       mrd, br, mds, req, rdy;
        logic [9:0] exp;
    } vec_t;
    vec_t vecs[12];

    pipeline_controller #(
        .MD_LATENCY (MD_LAT),
        .CNT_W      (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rs_id        (rs_id),
        .rt_id        (rt_id),
        .rt_ex        (rt_ex),
        .mem_read_ex  (mem_read_ex),
        .branch_taken (branch_taken),
        .md_start     (md_start),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_write  (id_ex_write),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_write (ex_mem_write),
        .ex_mem_flush (ex_mem_flush),
        .mem_wb_flush (mem_wb_flush),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clock = ~clock;

    assign outs = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                   ex_mem_write, ex_mem_flush, mem_wb_flush, md_busy, md_done};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rtx, input logic mrd, input logic br,
                         input logic mds, input logic req, input logic rdy);
        reset        = rst;
        rs_id        = rs;
        rt_id        = rt;
        rt_ex        = rtx;
        mem_read_ex  = mrd;
        branch_taken = br;
        md_start     = mds;
        dmem_req     = req;
        dmem_ready   = rdy;
    endtask

    // Expected strobes for the present cycle, straight from the priority rules.
    function automatic logic [9:0] model_out();
        logic hazard;
        hazard = mem_read_ex && (rt_ex != 5'd0) && (rs_id == rt_ex || rt_id == rt_ex);
        if (reset)                    return E_RST;
        if (md_left > 0)              return (md_left == 1) ? E_DONE : E_MD;
        if (mem_wait)                 return dmem_ready ? E_RUN : E_MEM;
        if (dmem_req && !dmem_ready)  return E_MEM;
        if (branch_taken)             return E_BR;
        if (md_start)                 return E_MD;
        if (hazard)                   return E_LU;
        return E_RUN;
    endfunction

    task automatic model_update(input logic [9:0] e);
        if (reset) begin
            md_left  = 0;
            mem_wait = 1'b0;
            m_stall  = 32'd0;
            m_flush  = 32'd0;
        end else begin
            if (!e[9]) m_stall = m_stall + 32'd1;
            if (e == E_BR) m_flush = m_flush + 32'd1;
            if (md_left > 0) begin
                md_left = md_left - 1;
            end else if (mem_wait) begin
                mem_wait = !dmem_ready;
            end else if (dmem_req && !dmem_ready) begin
                mem_wait = 1'b1;
            end else if (!branch_taken && md_start) begin
                md_left = MD_LAT - 1;
            end
        end
    endtask

    // Compare the present cycle against the model, then advance one clock.
    task automatic tick();
        logic [9:0] e;
        e = model_out();
        check("strobes", {22'd0, outs}, {22'd0, e});
`ifdef PIPELINE_CTRL_PERF_EN
        check("stall_cycles", stall_cycles, m_stall);
        check("flush_count", flush_count, m_flush);
`else
        check("stall_cycles", stall_cycles, 32'd0);
        check("flush_count", flush_count, 32'd0);
`endif
        @(posedge clock);
        model_update(e);
        @(negedge clock);
    endtask

    task automatic idle_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        tick();
    endtask

    initial begin
        int busy_n;
        int done_at;

        vecs[0]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN};
        vecs[1]  = '{5'd5,  5'd1,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_LU};
        vecs[2]  = '{5'd2,  5'd5,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_LU};
        vecs[3]  = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN};
        vecs[4]  = '{5'd5,  5'd5,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN};
        vecs[5]  = '{5'd6,  5'd7,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN};
        vecs[6]  = '{5'd5,  5'd5,  5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_BR};
        vecs[7]  = '{5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_MD};
        vecs[8]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_BR};
        vecs[9]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, E_MEM};
        vecs[10] = '{5'd9,  5'd0,  5'd9,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, E_LU};
        vecs[11] = '{5'd31, 5'd3,  5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_LU};

        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);

        // Reset held two cycles, then the first free-running cycle.
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1; check("reset_strobes", {22'd0, outs}, {22'd0, E_RST}); tick();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1; check("reset_strobes_2", {22'd0, outs}, {22'd0, E_RST}); tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1; check("first_run", {22'd0, outs}, {22'd0, E_RUN}); tick();

        // Single-cycle RUN-state table, each vector followed by a clearing reset.
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, vecs[i].rs, vecs[i].rt, vecs[i].rtx, vecs[i].mrd, vecs[i].br,
                  vecs[i].mds, vecs[i].req, vecs[i].rdy);
            #1; check($sformatf("table[%0d]", i), {22'd0, outs}, {22'd0, vecs[i].exp});
            tick();
            idle_reset();
        end

        // Load-use stalls exactly one cycle, then clears once the load moves on.
        drive(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1; check("lu_stall", {22'd0, outs}, {22'd0, E_LU}); tick();
        drive(1'b0, 5'd5, 5'd0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1; check("lu_release", {22'd0, outs}, {22'd0, E_RUN}); tick();

        // Load-use together with a branch: flush wins, flush counter 0 -> 1.
        idle_reset();
        drive(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1; check("br_over_lu", {22'd0, outs}, {22'd0, E_BR});
        check("flush_before", flush_count, 32'd0);
        tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
`ifdef PIPELINE_CTRL_PERF_EN
        check("flush_after", flush_count, 32'd1);
`else
        check("flush_after", flush_count, 32'd0);
`endif
        tick();

        // Mult/div pulse: busy for MD_LAT cycles, done on the last; branches ignored.
        busy_n  = 0;
        done_at = -1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1; if (md_busy) busy_n++; if (md_done) done_at = 0; tick();
        for (int i = 1; i < MD_LAT + 2; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, (i < MD_LAT), 1'b0, 1'b1, 1'b0);
            if (i >= MD_LAT) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            #1; if (md_busy) busy_n++; if (md_done) done_at = i; tick();
        end
        check("md_busy_cycles", busy_n, MD_LAT);
        check("md_done_cycle", done_at, MD_LAT - 1);

        // Data-memory wait three cycles with md_start pending, then the mult/div.
        idle_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            #1; check($sformatf("mem_wait_exw[%0d]", i), {31'd0, ex_mem_write}, 32'd0); tick();
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        #1; check("mem_ready", {22'd0, outs}, {22'd0, E_RUN}); tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1; check("md_after_mem", {22'd0, outs}, {22'd0, E_MD}); tick();
        for (int i = 0; i < MD_LAT; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            #1; tick();
        end

        // Reset on the second MD_WAIT cycle aborts silently to RUN.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1; tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1; tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1; check("md_wait_2nd", {22'd0, outs}, {22'd0, E_MD});
        reset = 1'b1;
        #1; check("md_abort_reset", {22'd0, outs}, {22'd0, E_RST}); tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1; check("after_abort", {22'd0, outs}, {22'd0, E_RUN}); tick();
        #1; check("no_late_done", {31'd0, md_done}, 32'd0); tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(63) == 0),
                  5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                  ($urandom_range(2) == 0), ($urandom_range(5) == 0),
                  ($urandom_range(5) == 0), ($urandom_range(2) == 0),
                  ($urandom_range(1) == 0));
            #1; tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
